// File: rtl/result_writeback_pkg.sv
// Shared definitions for the writeback (store-side) unit and its load-side sibling.
package result_writeback_pkg;

    // Run-control states shared by the load- and store-side units.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    localparam logic [7:0] PIX_MAX = 8'hFF;

    // Signed 32-bit lane result to 8-bit pixel: clamp to 0..255, or keep the low byte.
    function automatic logic [7:0] to_pixel(input logic [31:0] value, input logic truncate);
        logic [7:0] pix;
        if (truncate) begin
            pix = value[7:0];
        end else if (value[31]) begin
            pix = 8'h00;
        end else if (value[30:8] != '0) begin
            pix = PIX_MAX;
        end else begin
            pix = value[7:0];
        end
        return pix;
    endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Run control, input vector stream and memory write port of the writeback unit.
interface result_writeback_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              pack_mode;
    logic [31:0]       r1;
    logic [31:0]       r2;
    logic [31:0]       r3;
    logic [31:0]       r4;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wr_ack;
    logic              busy;
    logic              done;

    // The writeback unit: consumes vectors, masters the memory write port.
    modport master (
        input  start, base_addr, in_valid, pack_mode, r1, r2, r3, r4, mem_wr_ack,
        output in_ready, mem_wr_en, mem_addr, mem_wdata, busy, done
    );

    // The surrounding system: produces vectors, acknowledges memory writes.
    modport slave (
        output start, base_addr, in_valid, pack_mode, r1, r2, r3, r4, mem_wr_ack,
        input  in_ready, mem_wr_en, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/result_writeback_pixel_pack.sv
// Converts four 32-bit lane results to pixels and packs them, lane 1 in the low byte.
module result_writeback_pixel_pack
    import result_writeback_pkg::*;
(
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] r3,
    input  logic [31:0] r4,
    input  logic        pack_mode,
    output logic [31:0] word
);

    // Per-lane conversion, concatenated {p4, p3, p2, p1}.
    always_comb begin
        word = {to_pixel(r4, pack_mode), to_pixel(r3, pack_mode),
                to_pixel(r2, pack_mode), to_pixel(r1, pack_mode)};
    end

endmodule

// File: rtl/result_writeback.sv
// Packs 4-lane result vectors into pixel words and writes a run of NUM_WORDS words
// to consecutive memory addresses through a 2-entry FIFO.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    result_writeback_if.master bus
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] FLUSH = ST_FLUSH;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam int unsigned    CNT_W    = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  acc_q, acc_d;

    logic [31:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;

    logic [31:0] packed_word;
    logic        in_ready, mem_wr_en, push, pop;

    result_writeback_pixel_pack pixel_pack (
        .r1        (bus.r1),
        .r2        (bus.r2),
        .r3        (bus.r3),
        .r4        (bus.r4),
        .pack_mode (bus.pack_mode),
        .word      (packed_word)
    );

    // Handshakes; a full FIFO blocks acceptance even if it is popped this cycle.
    always_comb begin
        in_ready  = (state_q == RUN) && (count_q != 2'd2) && (acc_q < NUM_CNT);
        mem_wr_en = (count_q != 2'd0) && ((state_q == RUN) || (state_q == FLUSH));
        push      = bus.in_valid && in_ready;
        pop       = mem_wr_en && bus.mem_wr_ack;
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Run FSM with write-address and accepted-vector counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        if (pop) begin
            addr_d = addr_q + 1'b1;
        end
        if (push) begin
            acc_d = acc_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    addr_d  = bus.base_addr;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (push && (acc_q == LAST_CNT)) begin
                    state_d = FLUSH;
                end
            end
            // Leave on the edge of the final ack so done follows it by exactly one cycle.
            FLUSH: begin
                if (count_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
        end
    end

    // Two-entry FIFO of packed words; reset discards any buffered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= packed_word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Outputs; write data reads as zero whenever no write is requested.
    always_comb begin
        bus.in_ready  = in_ready;
        bus.mem_wr_en = mem_wr_en;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = mem_wr_en ? fifo_q[rd_ptr_q] : 32'h0;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
    end

endmodule

// File: doc/result_writeback.md
# result_writeback

Store-side counterpart of the four-lane execution stage. Accepts one 4-lane result vector per handshake, converts each 32-bit lane result to an 8-bit pixel (clamped or truncated), packs the four pixels into one 32-bit word, buffers it in a 2-entry FIFO and writes it to data memory at consecutive addresses. A run covers exactly NUM_WORDS words, starting at a programmable base address, and ends with a one-cycle done pulse.

## Interface

- ADDR_W, 16, memory word-address width
- NUM_WORDS, 1024, words per run (≥1, ≤ 2^ADDR_W)
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
- base_addr  in  ADDR_W  first write address, sampled on accepted start
- in_valid  in  1  r1..r4 and pack_mode valid
- in_ready  out  1  block can accept a vector this cycle
- pack_mode  in  1  0 = clamp, 1 = truncate; travels with the vector
- r1, r2, r3, r4  in  32 each  lane results (signed two's complement)
- mem_wr_en  out  1  write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  packed pixel word
- mem_wr_ack  in  1  memory accepted the write this cycle
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run

## Operation

- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0, mem_wr_en=0. start=1 → RUN; addr_cnt←base_addr, acc_cnt←0.
- RUN: vector accepted when in_valid && in_ready; acc_cnt increments. When acc_cnt reaches NUM_WORDS → FLUSH.
- FLUSH: no acceptance; stays until FIFO empty and no write outstanding → DONE.
- DONE: done=1 one cycle → IDLE.
- in_ready = (state==RUN) && FIFO not full && acc_cnt<NUM_WORDS. No full-FIFO bypass: a simultaneous pop does not raise in_ready in the same cycle.
- Pixel conversion per lane, pack_mode=0: value<0 → 0x00; value>255 → 0xFF; else low byte. pack_mode=1: low 8 bits, no clamp.
- Packing: mem_wdata = {p4,p3,p2,p1}; p1 in bits 7:0.
- Conversion and packing happen before the FIFO push; the FIFO stores 32-bit packed words.
- Write side: mem_wr_en = FIFO non-empty (RUN or FLUSH). mem_addr = addr_cnt, mem_wdata = FIFO head. Both remain stable until mem_wr_ack. On ack: pop and addr_cnt+1, wrapping modulo 2^ADDR_W.
- mem_wr_ack while mem_wr_en=0 is ignored.
- start outside IDLE is ignored.

## Timing

- Reset values:
  - state=IDLE.
  - in_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
  - FIFO empty, counters 0.
- Latency: a vector accepted at edge N yields mem_wr_en=1 at cycle N+1 at the earliest (registered FIFO output).
- Throughput: one word per cycle when mem_wr_ack is held high.
- A push and a pop in the same cycle with FIFO occupancy 1 both occur; occupancy stays 1.
- Reset mid-run: abandon immediately, discard buffered words, drop mem_wr_en asynchronously with rst, no done pulse.
- done is asserted exactly one cycle after the last ack, i.e. the first cycle in DONE.

## Structure

- Shared package: state enum (IDLE/RUN/FLUSH/DONE) and PIX_MAX=8'hFF constant, for reuse by the load-side unit.
- Sub-module: pixel_pack. Combinational: four 32-bit lanes + pack_mode → 32-bit word; instantiated once.
- The 2-entry FIFO and the FSM/counters stay inline.

## Test plan

- Clamp: pack_mode=0, r1=-5, r2=300, r3=128, r4=255 → mem_wdata=0xFF80FF00.
- Truncate: pack_mode=1, r1=0x1234, r2=-1, r3=0x100, r4=7 → mem_wdata=0x0700FF34.
- Backpressure: NUM_WORDS=4, base_addr=0x10, mem_wr_ack held low 10 cycles → in_ready drops after 2 accepts; then ack every cycle → writes to 0x10..0x13 in order, done pulses once, busy falls.
- Wrap-around: ADDR_W=4, base_addr=0xE, NUM_WORDS=4 → addresses 0xE, 0xF, 0x0, 0x1.
- Reset mid-run: assert rst with 2 words buffered and mem_wr_en high → all outputs 0, no done; a new start runs cleanly from its base_addr.
- Ignored inputs: start pulsed during RUN and stray mem_wr_ack in IDLE → no state, counter or address change.
